sr_uart_word_tx: RTL and testbench



---
 rtl/sr_uart_word_tx.sv | 82 ++++++++
 tb/tb_sr_uart_word_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sr_uart_word_tx.sv
// sr_uart_word_tx: 32-bit word UART transmitter, low byte first, LSB first; 8N1, or 8E1 when SR_UART_TX_PARITY_EN is defined
module sr_uart_word_tx #(
  parameter int CLK_PER_BIT = 5208,
  parameter int CNT_W = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  output logic        word_ready,
  output logic        busy,
  output logic        tx
);
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
`ifdef SR_UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_BIT - 1);
  state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0] bit_q;
  logic [1:0] byte_q;
  logic [31:0] shadow_q;
  logic tx_q;
  logic [7:0] cur_byte;
  logic bit_end;
  logic tx_d;
  // line level for the current state; registered below, so tx trails the state by one clock
  always_comb begin
    cur_byte = shadow_q[{byte_q, 3'b000} +: 8];
    bit_end = cnt_q == CNT_MAX;
`ifdef SR_UART_TX_PARITY_EN
    tx_d = state_q == START ? 1'b0 : state_q == DATA ? cur_byte[bit_q] : state_q == PARITY ? ^cur_byte : 1'b1;
`else
    tx_d = state_q == START ? 1'b0 : state_q == DATA ? cur_byte[bit_q] : 1'b1;
`endif
  end
  // frame sequencer: accept a word, then START/DATA/(PARITY)/STOP for each of the four bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      shadow_q <= '0;
      tx_q <= 1'b1;
    end else begin
      tx_q <= tx_d;
      cnt_q <= (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: if (word_valid) begin
          shadow_q <= word_data;
          byte_q <= '0;
          bit_q <= '0;
          state_q <= START;
        end
        START: if (bit_end) state_q <= DATA;
        DATA: if (bit_end) begin
          bit_q <= bit_q == 3'd7 ? 3'd0 : bit_q + 3'd1;
`ifdef SR_UART_TX_PARITY_EN
          if (bit_q == 3'd7) state_q <= PARITY;
`else
          if (bit_q == 3'd7) state_q <= STOP;
`endif
        end
`ifdef SR_UART_TX_PARITY_EN
        PARITY: if (bit_end) state_q <= STOP;
`endif
        STOP: if (bit_end) begin
          byte_q <= byte_q == 2'd3 ? byte_q : byte_q + 2'd1;
          state_q <= byte_q == 2'd3 ? IDLE : START;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign word_ready = state_q == IDLE && !rst;
  assign busy = state_q != IDLE;
  assign tx = tx_q;
endmodule

// File: tb/tb_sr_uart_word_tx.sv
// tb_sr_uart_word_tx: line-level model plus mid-bit receiver checking sr_uart_word_tx at CLK_PER_BIT=4
module tb_sr_uart_word_tx;
  localparam int CPB = 4;
`ifdef SR_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = 10 + PAR;
  localparam int WORD_CLKS = PAR ? 176 : 160;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic word_valid = 1'b0;
  logic [31:0] word_data = '0;
  logic word_ready, busy, tx;
  int checks = 0;
  int failures = 0;
  sr_uart_word_tx #(.CLK_PER_BIT(CPB), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready), .busy(busy), .tx(tx)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  int busy_left = 0;
  logic exp_tx = 1'b1;
  logic line_q[$];
  function automatic void push_bit(input logic v);
    repeat (CPB) line_q.push_back(v);
  endfunction
  function automatic void push_frame(input logic [31:0] w);
    for (int j = 0; j < 4; j++) begin
      logic [7:0] b;
      b = w[8*j +: 8];
      push_bit(1'b0);
      for (int k = 0; k < 8; k++) push_bit(b[k]);
      if (PAR != 0) push_bit(^b);
      push_bit(1'b1);
    end
  endfunction
  int rx_cnt = -1;
  logic [10:0] rx_bits = '0;
  logic [7:0] rx_bytes[$];
  logic rx_par[$];
  logic [10:0] rx_frames[$];
  always @(posedge clk) begin
    logic acc;
    int idx;
    if (rst) begin
      busy_left = 0;
      line_q.delete();
      exp_tx = 1'b1;
    end else begin
      acc = word_valid && busy_left == 0;
      exp_tx = line_q.size() > 0 ? line_q.pop_front() : 1'b1;
      if (busy_left > 0) busy_left--;
      if (acc) begin
        busy_left = WORD_CLKS;
        push_frame(word_data);
      end
    end
    #1;
    check("tx", tx, exp_tx);
    check("busy", busy, busy_left > 0);
    check("word_ready", word_ready, busy_left == 0 && !rst);
    if (rst) rx_cnt = -1;
    else if (rx_cnt < 0) begin
      if (!tx) rx_cnt = 0;
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        idx = rx_cnt / CPB;
        rx_bits[idx] = tx;
        if (idx == FRAME - 1) begin
          check("start_bit", rx_bits[0], 1'b0);
          check("stop_bit", rx_bits[FRAME-1], 1'b1);
          rx_bytes.push_back(rx_bits[8:1]);
          if (PAR != 0) rx_par.push_back(rx_bits[9]);
          rx_frames.push_back(rx_bits);
          rx_cnt = -1;
        end
      end
    end
  end
  task automatic clear_rx();
    rx_bytes.delete();
    rx_par.delete();
    rx_frames.delete();
  endtask
  function automatic logic [31:0] get_word();
    logic [31:0] w;
    if (rx_bytes.size() < 4) return 'x;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = rx_bytes.pop_front();
    return w;
  endfunction
  task automatic send(input logic [31:0] w);
    @(negedge clk);
    word_valid = 1'b1;
    word_data = w;
    @(negedge clk);
    word_valid = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask
  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_ready", word_ready, 1'b0);
      word_valid = ~word_valid;
    end
    @(negedge clk);
    rst = 1'b0;
    word_valid = 1'b0;
    #1;
    check("ready_after_rst", word_ready, 1'b1);
    clear_rx();
    send(32'ha5981537);
    wait_done(n);
    check("single_busy_clks", n, WORD_CLKS);
    repeat (4) @(negedge clk);
    check("single_rx_bytes", rx_bytes.size(), 4);
    check("single_byte0_bits", {23'd0, rx_frames[0][8:0]}, 32'h06e);
    check("single_byte0_stop", rx_frames[0][FRAME-1], 1'b1);
    check("single_word", get_word(), 32'ha5981537);
    clear_rx();
    @(negedge clk);
    word_valid = 1'b1;
    word_data = 32'ha5981537;
    @(negedge clk);
    word_data = 32'h87654321;
    wait_done(n);
    check("b2b_first_busy", n, WORD_CLKS);
    check("b2b_gap_ready", word_ready, 1'b1);
    @(negedge clk);
    check("b2b_accept_on_ready", busy, 1'b1);
    word_valid = 1'b0;
    wait_done(n);
    check("b2b_second_busy", n, WORD_CLKS);
    repeat (4) @(negedge clk);
    check("b2b_word0", get_word(), 32'ha5981537);
    check("b2b_word1", get_word(), 32'h87654321);
    clear_rx();
    send(32'h00000000);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      word_data = n[0] ? 32'hffffffff : $urandom;
      n++;
      @(negedge clk);
    end
    check("stab_busy_clks", n, WORD_CLKS);
    repeat (4) @(negedge clk);
    check("stab_word", get_word(), 32'h00000000);
    clear_rx();
    send(32'hcafef00d);
    repeat (88) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", word_ready, 1'b0);
    rst = 1'b0;
    clear_rx();
    send(32'h12345678);
    wait_done(n);
    check("midrst_busy_clks", n, WORD_CLKS);
    repeat (4) @(negedge clk);
    check("midrst_word", get_word(), 32'h12345678);
`ifdef SR_UART_TX_PARITY_EN
    clear_rx();
    send(32'h00000103);
    wait_done(n);
    check("par_word_clks", n, 176);
    repeat (4) @(negedge clk);
    check("par_count", rx_par.size(), 4);
    check("par_bit0", rx_par[0], 1'b0);
    check("par_bit1", rx_par[1], 1'b1);
    check("par_bit2", rx_par[2], 1'b0);
    check("par_bit3", rx_par[3], 1'b0);
    check("par_word", get_word(), 32'h00000103);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end
endmodule
